pulse_sync_sched: RTL and testbench

- Fast-domain scheduler in front of the 4-lane pulse synchronizer (4 x pulse_sync, OR-ed busy).
- Accepts event pulses on 4 lanes at any rate and counts them per lane, so no event is lost while the synchronizer is busy.
- Issues at most one synchronizer pulse per lane per transfer. It issues only when the synchronizer is idle, then waits for the transfer to finish.
- Sits in the fast (clk_a) domain between event sources and the synchronizer's sig_4bit/busy.

---
 rtl/pulse_sync_pkg.sv | 30 +++
 rtl/pulse_sync_sched_if.sv | 48 ++++
 rtl/pulse_sync_sched_pend_cnt.sv | 87 ++++++++
 rtl/pulse_sync_sched.sv | 139 +++++++++++++
 tb/tb_pulse_sync_sched.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_sync_pkg.sv
// -----------------------------------------------------------------------------
// pulse_sync_pkg
// Shared definitions for the pulse synchronizer scheduler slice:
//   - lane count of the downstream 4-lane pulse synchronizer
//   - default counter width and busy-rise wait limit
//   - scheduler FSM state encoding
// -----------------------------------------------------------------------------
package pulse_sync_pkg;

    // Number of event lanes (one pulse_sync per lane downstream).
    localparam int NUM_LANES     = 4;

    // Default width of each per-lane pending counter.
    localparam int DEF_CNT_W     = 4;

    // Default number of WAIT_HI cycles allowed for sync_busy to rise.
    localparam int DEF_BUSY_WAIT = 3;

    // Width of the busy-rise wait counter; covers BUSY_WAIT up to 15.
    localparam int WAIT_W        = 4;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } sched_state_e;

endpackage : pulse_sync_pkg

// File: rtl/pulse_sync_sched_if.sv
// -----------------------------------------------------------------------------
// pulse_sync_sched_if
// Groups the event-side, synchronizer-side and status signals of the
// pulse_sync_sched block.
//   ev_in     : event pulses, one bit per lane
//   sync_busy : busy from the downstream synchronizer
//   err_clr   : clears the sticky error flags
//   sig_4bit  : one-cycle pulses to the synchronizer
//   pend_nz   : per-lane pending count non-zero
//   overflow  : sticky per-lane counter overflow
//   busy_tmo  : sticky busy-rise timeout
//   idle      : scheduler idle and nothing pending
// Modport slave is the scheduler side, master is the environment side.
// -----------------------------------------------------------------------------
interface pulse_sync_sched_if;

    logic [pulse_sync_pkg::NUM_LANES-1:0] ev_in;
    logic                                 sync_busy;
    logic                                 err_clr;
    logic [pulse_sync_pkg::NUM_LANES-1:0] sig_4bit;
    logic [pulse_sync_pkg::NUM_LANES-1:0] pend_nz;
    logic [pulse_sync_pkg::NUM_LANES-1:0] overflow;
    logic                                 busy_tmo;
    logic                                 idle;

    modport slave (
        input  ev_in,
        input  sync_busy,
        input  err_clr,
        output sig_4bit,
        output pend_nz,
        output overflow,
        output busy_tmo,
        output idle
    );

    modport master (
        output ev_in,
        output sync_busy,
        output err_clr,
        input  sig_4bit,
        input  pend_nz,
        input  overflow,
        input  busy_tmo,
        input  idle
    );

endinterface : pulse_sync_sched_if

// File: rtl/pulse_sync_sched_pend_cnt.sv
// -----------------------------------------------------------------------------
// pend_cnt
// Saturating per-lane pending-event counter with sticky overflow flag.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   inc_i     : one event arrived this cycle
//   dec_i     : one event issued this cycle (only asserted when count != 0)
//   err_clr_i : clears the overflow flag
//   nz_o      : count is non-zero
//   ovf_o     : sticky, an event arrived while the count was saturated
// -----------------------------------------------------------------------------
module pend_cnt #(
    parameter int CNT_W = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    input  logic err_clr_i,
    output logic nz_o,
    output logic ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             ovf_set_s;

    // Next count: inc and dec together cancel, saturation holds the count.
    always_comb begin
        cnt_d     = cnt_q;
        ovf_set_s = 1'b0;
        case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q == CNT_MAX) begin
                    ovf_set_s = 1'b1;
                    cnt_d     = cnt_q;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            2'b01: begin
                // Guard against underflow even though the issue mask never
                // selects an empty lane.
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Sticky overflow: a new overflow wins over a clear in the same cycle.
    always_comb begin
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (err_clr_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Counter and overflow state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= CNT_ZERO;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign nz_o  = (cnt_q != CNT_ZERO);
    assign ovf_o = ovf_q;

endmodule : pend_cnt

// File: rtl/pulse_sync_sched.sv
// -----------------------------------------------------------------------------
// pulse_sync_sched
// Fast-domain scheduler in front of a 4-lane pulse synchronizer. Events are
// counted per lane; when the synchronizer is idle all pending lanes are
// issued together as a one-cycle pulse on sig_4bit, then the scheduler waits
// for sync_busy to rise and fall before the next transfer.
//   clk_a : fast clock
//   rst   : synchronous active-high reset
//   bus   : pulse_sync_sched_if.slave
//           ev_in / sync_busy / err_clr in,
//           sig_4bit / pend_nz / overflow / busy_tmo / idle out
// -----------------------------------------------------------------------------
module pulse_sync_sched
    import pulse_sync_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BUSY_WAIT = DEF_BUSY_WAIT
) (
    input  logic               clk_a,
    input  logic               rst,
    pulse_sync_sched_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_ISSUE   = ST_ISSUE;
    localparam logic [1:0] S_WAIT_HI = ST_WAIT_HI;
    localparam logic [1:0] S_WAIT_LO = ST_WAIT_LO;

    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(BUSY_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [WAIT_W-1:0]    wait_q;
    logic [WAIT_W-1:0]    wait_d;
    logic [NUM_LANES-1:0] sig_q;
    logic [NUM_LANES-1:0] sig_d;
    logic                 tmo_q;
    logic                 tmo_d;
    logic                 tmo_set_s;
    logic [NUM_LANES-1:0] nz_s;
    logic [NUM_LANES-1:0] ovf_s;

    // Per-lane pending counters. sig_q is only non-zero during ISSUE, so it
    // doubles as the issue mask that decrements the selected lanes.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pend_cnt #(
            .CNT_W (CNT_W)
        ) u_pend_cnt (
            .clk_i     (clk_a),
            .rst_i     (rst),
            .inc_i     (bus.ev_in[i]),
            .dec_i     (sig_q[i]),
            .err_clr_i (bus.err_clr),
            .nz_o      (nz_s[i]),
            .ovf_o     (ovf_s[i])
        );
    end

    // Scheduler FSM next-state, issue mask and busy-rise wait counter.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        sig_d     = {NUM_LANES{1'b0}};
        tmo_set_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The mask is loaded with the transition so the pulse is
                // registered and visible in the ISSUE cycle itself.
                if ((|nz_s) && !bus.sync_busy) begin
                    sig_d   = nz_s;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                wait_d  = WAIT_ZERO;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (bus.sync_busy) begin
                    state_d = S_WAIT_LO;
                end else if ((wait_q + WAIT_ONE) == WAIT_LIM) begin
                    // Busy never rose: flag it and treat the transfer as done.
                    tmo_set_s = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d  = wait_q + WAIT_ONE;
                    state_d = S_WAIT_HI;
                end
            end
            S_WAIT_LO: begin
                if (!bus.sync_busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky timeout: a new timeout wins over a clear in the same cycle.
    always_comb begin
        if (tmo_set_s) begin
            tmo_d = 1'b1;
        end else if (bus.err_clr) begin
            tmo_d = 1'b0;
        end else begin
            tmo_d = tmo_q;
        end
    end

    // FSM, wait counter, pulse and timeout registers.
    always_ff @(posedge clk_a) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= WAIT_ZERO;
            sig_q   <= {NUM_LANES{1'b0}};
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            sig_q   <= sig_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.sig_4bit = sig_q;
    assign bus.pend_nz  = nz_s;
    assign bus.overflow = ovf_s;
    assign bus.busy_tmo = tmo_q;
    assign bus.idle     = (state_q == S_IDLE) && !(|nz_s);

endmodule : pulse_sync_sched

// File: tb/tb_pulse_sync_sched.sv
// -----------------------------------------------------------------------------
// tb_pulse_sync_sched
// Self-checking bench for pulse_sync_sched. Expected synchronizer pulses are
// queued as stimulus is applied and popped by a monitor whenever sig_4bit is
// non-zero; cycle-exact points are checked directly.
// -----------------------------------------------------------------------------
module tb_pulse_sync_sched;

    logic clk;
    logic rst;

    int   n_tests;
    int   n_fail;

    // Synchronizer busy model controls.
    bit   busy_force;
    bit   model_en;
    int   hi_left;
    bit   start_pend;

    logic [3:0] exp_q[$];

    pulse_sync_sched_if bus_if ();

    pulse_sync_sched #(
        .CNT_W     (4),
        .BUSY_WAIT (3)
    ) dut (
        .clk_a (clk),
        .rst   (rst),
        .bus   (bus_if)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point; counts and reports.
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits a bounded number of cycles for idle, then checks it.
    task automatic wait_idle(input string tag, input int max_cyc);
        int k;
        k = 0;
        while (bus_if.idle !== 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
        check_val(tag, 32'(bus_if.idle), 32'd1);
    endtask

    // Synchronizer model: busy rises the cycle after an issue, for 6 cycles.
    initial begin
        hi_left           = 0;
        start_pend        = 1'b0;
        bus_if.sync_busy  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hi_left > 0) hi_left--;
            if (start_pend) begin
                hi_left    = 6;
                start_pend = 1'b0;
            end
            if (model_en && (bus_if.sig_4bit != 4'b0000)) start_pend = 1'b1;
            bus_if.sync_busy = busy_force || (hi_left > 0);
        end
    end

    // Scoreboard monitor: every issued pulse must match the next expected mask.
    always @(negedge clk) begin
        if (bus_if.sig_4bit != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", 32'(bus_if.sig_4bit), 32'd0);
            end else begin
                check_val("pulse_mask", 32'(bus_if.sig_4bit), 32'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        busy_force     = 1'b0;
        model_en       = 1'b0;
        rst            = 1'b1;
        bus_if.ev_in   = 4'b0000;
        bus_if.err_clr = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_sig",   32'(bus_if.sig_4bit), 32'd0);
        check_val("rst_idle",  32'(bus_if.idle),     32'd1);
        check_val("rst_pend",  32'(bus_if.pend_nz),  32'd0);
        check_val("rst_ovf",   32'(bus_if.overflow), 32'd0);
        check_val("rst_tmo",   32'(bus_if.busy_tmo), 32'd0);
        rst      = 1'b0;
        model_en = 1'b1;
        tick();

        // ---------------- single event ----------------
        exp_q.push_back(4'b0001);
        bus_if.ev_in = 4'b0001;
        tick();
        bus_if.ev_in = 4'b0000;
        check_val("t1_pend_t1", 32'(bus_if.pend_nz), 32'h1);
        check_val("t1_sig_t1",  32'(bus_if.sig_4bit), 32'd0);
        tick();
        check_val("t1_sig_t2",  32'(bus_if.sig_4bit), 32'h1);
        tick();
        check_val("t1_sig_once", 32'(bus_if.sig_4bit), 32'd0);
        check_val("t1_busy_idle", 32'(bus_if.idle), 32'd0);
        wait_idle("t1_idle", 40);
        check_val("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- backlog while busy ----------------
        busy_force = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_if.ev_in = (i == 3) ? 4'b0001 : 4'b0100;
            tick();
        end
        bus_if.ev_in = 4'b0000;
        tick();
        check_val("t2_pend", 32'(bus_if.pend_nz), 32'h5);
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0100);
        busy_force = 1'b0;
        wait_idle("t2_idle", 200);
        check_val("t2_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("t2_pend_end", 32'(bus_if.pend_nz), 32'd0);

        // ---------------- saturation ----------------
        busy_force = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            bus_if.ev_in = 4'b1000;
            tick();
            if (i == 14) check_val("t3_ovf_at_max", 32'(bus_if.overflow), 32'd0);
        end
        check_val("t3_ovf_set", 32'(bus_if.overflow), 32'h8);
        // Overflow in the same cycle as err_clr keeps the flag set.
        bus_if.err_clr = 1'b1;
        tick();
        bus_if.err_clr = 1'b0;
        bus_if.ev_in   = 4'b0000;
        check_val("t3_set_wins", 32'(bus_if.overflow), 32'h8);
        check_val("t3_pend", 32'(bus_if.pend_nz), 32'h8);
        for (int i = 0; i < 15; i++) exp_q.push_back(4'b1000);
        busy_force = 1'b0;
        wait_idle("t3_idle", 400);
        check_val("t3_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("t3_ovf_sticky", 32'(bus_if.overflow), 32'h8);
        bus_if.err_clr = 1'b1;
        tick();
        bus_if.err_clr = 1'b0;
        check_val("t3_ovf_clr", 32'(bus_if.overflow), 32'd0);

        // ---------------- simultaneous inc/dec ----------------
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0010);
        bus_if.ev_in = 4'b0010;
        tick();
        bus_if.ev_in = 4'b0000;
        tick();
        check_val("t4_issue", 32'(bus_if.sig_4bit), 32'h2);
        bus_if.ev_in = 4'b0010;
        tick();
        bus_if.ev_in = 4'b0000;
        check_val("t4_pend_kept", 32'(bus_if.pend_nz), 32'h2);
        wait_idle("t4_idle", 80);
        check_val("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- busy-rise timeout ----------------
        model_en = 1'b0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        bus_if.ev_in = 4'b0001;
        tick();
        tick();
        bus_if.ev_in = 4'b0000;
        check_val("t5_issue", 32'(bus_if.sig_4bit), 32'h1);
        tick();
        tick();
        tick();
        check_val("t5_tmo_early", 32'(bus_if.busy_tmo), 32'd0);
        tick();
        check_val("t5_tmo_set", 32'(bus_if.busy_tmo), 32'd1);
        tick();
        check_val("t5_reissue", 32'(bus_if.sig_4bit), 32'h1);
        wait_idle("t5_idle", 20);
        check_val("t5_q_empty", 32'(exp_q.size()), 32'd0);
        bus_if.err_clr = 1'b1;
        tick();
        bus_if.err_clr = 1'b0;
        check_val("t5_tmo_clr", 32'(bus_if.busy_tmo), 32'd0);
        model_en = 1'b1;
        tick();

        // ---------------- reset mid-transfer ----------------
        exp_q.push_back(4'b0001);
        bus_if.ev_in = 4'b0001;
        tick();
        tick();
        tick();
        bus_if.ev_in = 4'b0000;
        tick();
        tick();
        check_val("t6_pend_pre", 32'(bus_if.pend_nz), 32'h1);
        check_val("t6_busy_pre", 32'(bus_if.sync_busy), 32'd1);
        rst = 1'b1;
        tick();
        check_val("t6_sig",  32'(bus_if.sig_4bit), 32'd0);
        check_val("t6_idle", 32'(bus_if.idle),     32'd1);
        check_val("t6_pend", 32'(bus_if.pend_nz),  32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_val("t6_idle_end", 32'(bus_if.idle), 32'd1);
        check_val("t6_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pulse_sync_sched
